tilt_axis_scheduler: RTL and testbench

- Time-multiplexes one `tilt_counter` measurement engine across up to `N_AXES` raw tilt inputs.
- Sequences each measurement: selects an axis, lets the mux settle, pulses start, then waits for done or timeout.
- Captures the returned count into a per-axis result register and moves to the next enabled axis in round-robin order.
- Sits between the tilt sensor pins and the counter instance; results feed downstream readout logic.

---
 rtl/tilt_pkg.sv | 22 ++
 rtl/tilt_rr_picker.sv | 31 +++
 rtl/tilt_axis_scheduler.sv | 150 +++++++++++++++
 tb/tb_tilt_axis_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_pkg.sv
// Shared types and width helpers for the tilt axis scheduler.
package tilt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_ADVANCE
    } tilt_sched_state_t;

    // Axis index width; a single-axis build still needs a 1-bit select.
    function automatic int axis_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/tilt_rr_picker.sv
// Round-robin search for the next enabled axis after the current one.
module tilt_rr_picker
    import tilt_pkg::*;
#(
    parameter int N_AXES = 3,
    parameter int AW     = axis_w(N_AXES)
) (
    input  logic [N_AXES-1:0] mask_i,
    input  logic [AW-1:0]     cur_axis_i,
    output logic [AW-1:0]     next_axis_o,
    output logic              found_o
);

    logic [AW-1:0] idx;

    // Candidates start one past the current axis, so the current axis is
    // considered last and only wins when it is the sole enabled one.
    always_comb begin
        next_axis_o = cur_axis_i;
        found_o     = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N_AXES; k++) begin
            idx = AW'((int'(cur_axis_i) + k) % N_AXES);
            if (!found_o && mask_i[idx]) begin
                found_o     = 1'b1;
                next_axis_o = idx;
            end
        end
    end

endmodule

// File: rtl/tilt_axis_scheduler.sv
// Shares one tilt_counter across N_AXES inputs: select, settle, start,
// wait for done or timeout, capture, then advance round-robin.
module tilt_axis_scheduler
    import tilt_pkg::*;
#(
    parameter int N_AXES         = 3,
    parameter int WIDTH          = 32,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_AXES-1:0]         axis_mask,
    input  logic [N_AXES-1:0]         tilt_in,
    output logic                      cnt_tilt,
    output logic                      cnt_start,
    input  logic                      cnt_done,
    input  logic [WIDTH-1:0]          cnt_count,
    output logic [N_AXES*WIDTH-1:0]   result,
    output logic [N_AXES-1:0]         result_valid,
    input  logic [N_AXES-1:0]         result_ack,
    output logic [N_AXES-1:0]         timeout_err,
    output logic                      busy,
    output logic [axis_w(N_AXES)-1:0] cur_axis
);

    localparam int AW = axis_w(N_AXES);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] AXIS_LAST   = AW'(N_AXES - 1);

    tilt_sched_state_t         state_q, state_d;
    logic [AW-1:0]             cur_axis_q, cur_axis_d;
    logic [SW-1:0]             settle_q, settle_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [N_AXES*WIDTH-1:0]   result_q, result_d;
    logic [N_AXES-1:0]         valid_q, valid_d;
    logic [N_AXES-1:0]         terr_q, terr_d;
    logic                      start_q, start_d;
    logic                      busy_q, busy_d;

    logic [AW-1:0]             pick_next;
    logic                      pick_found;

    tilt_rr_picker #(
        .N_AXES (N_AXES),
        .AW     (AW)
    ) u_picker (
        .mask_i      (axis_mask),
        .cur_axis_i  (cur_axis_q),
        .next_axis_o (pick_next),
        .found_o     (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        cur_axis_d = cur_axis_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        result_d   = result_q;
        valid_d    = valid_q & ~result_ack;
        terr_d     = terr_q;

        case (state_q)
            ST_IDLE, ST_ADVANCE: begin
                if (enable && pick_found) begin
                    state_d    = ST_SELECT;
                    cur_axis_d = pick_next;
                    settle_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_START;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                // Done takes priority over the timeout, including on the last cycle.
                if (cnt_done) begin
                    for (int i = 0; i < N_AXES; i++) begin
                        if (AW'(i) == cur_axis_q) begin
                            result_d[i*WIDTH +: WIDTH] = cnt_count;
                            valid_d[i]                 = 1'b1;
                            terr_d[i]                  = 1'b0;
                        end
                    end
                    state_d = ST_ADVANCE;
                end else if (tmo_q == TMO_LAST) begin
                    for (int i = 0; i < N_AXES; i++) begin
                        if (AW'(i) == cur_axis_q) begin
                            terr_d[i] = 1'b1;
                        end
                    end
                    state_d = ST_ADVANCE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_axis_q <= AXIS_LAST;
            settle_q   <= '0;
            tmo_q      <= '0;
            result_q   <= '0;
            valid_q    <= '0;
            terr_q     <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_axis_q <= cur_axis_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            terr_q     <= terr_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_tilt     = (state_q != ST_IDLE) && tilt_in[cur_axis_q];
    assign cnt_start    = start_q;
    assign busy         = busy_q;
    assign cur_axis     = cur_axis_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_tilt_axis_scheduler.sv
// Scoreboard bench for tilt_axis_scheduler with a simple tilt_counter model.
module tb_tilt_axis_scheduler;

    localparam int N = 3;
    localparam int W = 32;
    localparam int S = 4;
    localparam int T = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   axis_mask;
    logic [N-1:0]   tilt_in;
    logic           cnt_tilt;
    logic           cnt_start;
    logic           cnt_done;
    logic [W-1:0]   cnt_count;
    logic [N*W-1:0] result;
    logic [N-1:0]   result_valid;
    logic [N-1:0]   result_ack;
    logic [N-1:0]   timeout_err;
    logic           busy;
    logic [1:0]     cur_axis;

    logic [N-1:0]   auto_ack;
    logic [N-1:0]   man_ack;
    logic [N-1:0]   coll_ack;
    assign result_ack = auto_ack | man_ack | coll_ack;

    always #5 clk = ~clk;

    tilt_axis_scheduler #(
        .N_AXES         (N),
        .WIDTH          (W),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .axis_mask    (axis_mask),
        .tilt_in      (tilt_in),
        .cnt_tilt     (cnt_tilt),
        .cnt_start    (cnt_start),
        .cnt_done     (cnt_done),
        .cnt_count    (cnt_count),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .timeout_err  (timeout_err),
        .busy         (busy),
        .cur_axis     (cur_axis)
    );

    // Expected DUT events, and per-start behaviour for the counter model.
    logic [1:0]  exp_start_q[$];
    logic [33:0] exp_cap_q[$];
    logic [1:0]  exp_tmo_q[$];
    int          mdl_dly_q[$];
    logic [31:0] mdl_val_q[$];
    logic [2:0]  mdl_coll_q[$];

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    bit auto_en = 1'b1;
    int stray_req = 0;
    int stray_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event on axis %0d, expected none", name, act);
    endtask

    // A delay of 0 means done is never returned; longer than T also times out.
    task automatic push_meas(input logic [1:0] ax, input int dly, input logic [31:0] val,
                             input logic [2:0] coll);
        exp_start_q.push_back(ax);
        mdl_dly_q.push_back(dly);
        mdl_val_q.push_back(val);
        mdl_coll_q.push_back(coll);
        if (dly > 0 && dly <= T) exp_cap_q.push_back({ax, val});
        else exp_tmo_q.push_back(ax);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (start_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("start_wait_timeout", 64'(start_cnt), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_wait_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_valid0(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid0_wait_timeout", 64'(result_valid[0]), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, 64'(result == '0), 64'(1));
        check({tag, "_valid"}, 64'(result_valid), 64'(0));
        check({tag, "_terr"}, 64'(timeout_err), 64'(0));
        check({tag, "_start"}, 64'(cnt_start), 64'(0));
        check({tag, "_tilt"}, 64'(cnt_tilt), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_cur_axis"}, 64'(cur_axis), 64'(2));
    endtask

    // Counter model: done arrives dly cycles after the sampled start.
    initial begin
        int          dly;
        logic [31:0] val;
        logic [2:0]  coll;
        cnt_done  = 1'b0;
        cnt_count = '0;
        coll_ack  = '0;
        forever begin
            @(negedge clk);
            if (stray_done != stray_req) begin
                stray_done++;
                cnt_done  = 1'b1;
                cnt_count = 32'h0000_5555;
                @(posedge clk);
                #1;
                cnt_done  = 1'b0;
                cnt_count = '0;
            end else if (cnt_start) begin
                dly  = 10;
                val  = 32'hDEAD_BEEF;
                coll = '0;
                if (mdl_dly_q.size() > 0) begin
                    dly  = mdl_dly_q.pop_front();
                    val  = mdl_val_q.pop_front();
                    coll = mdl_coll_q.pop_front();
                end
                if (dly > 0) begin
                    @(posedge clk);
                    repeat (dly - 1) @(posedge clk);
                    #1;
                    cnt_done  = 1'b1;
                    cnt_count = val;
                    coll_ack  = coll;
                    @(posedge clk);
                    #1;
                    cnt_done  = 1'b0;
                    cnt_count = '0;
                    coll_ack  = '0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every start, capture and timeout.
    initial begin
        logic [2:0]  vp;
        logic [2:0]  tp;
        logic [1:0]  ea;
        logic [33:0] ec;
        vp       = '0;
        tp       = '0;
        auto_ack = '0;
        forever begin
            @(negedge clk);
            auto_ack = '0;
            if (cnt_start) begin
                start_cnt++;
                if (exp_start_q.size() == 0) begin
                    fail_evt("unexpected_start", 64'(cur_axis));
                end else begin
                    ea = exp_start_q.pop_front();
                    check("start_axis", 64'(cur_axis), 64'(ea));
                    check("start_tilt", 64'(cnt_tilt), 64'(tilt_in[ea]));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (result_valid[i] && !vp[i]) begin
                    if (exp_cap_q.size() == 0) begin
                        fail_evt("unexpected_capture", 64'(i));
                    end else begin
                        ec = exp_cap_q.pop_front();
                        check("cap_axis", 64'(i), 64'(ec[33:32]));
                        check("cap_value", 64'(result[i*W +: W]), 64'(ec[31:0]));
                        check("cap_terr_clear", 64'(timeout_err[i]), 64'(0));
                    end
                    if (auto_en) auto_ack[i] = 1'b1;
                end
                if (timeout_err[i] && !tp[i]) begin
                    if (exp_tmo_q.size() == 0) begin
                        fail_evt("unexpected_timeout", 64'(i));
                    end else begin
                        ea = exp_tmo_q.pop_front();
                        check("tmo_axis", 64'(i), 64'(ea));
                    end
                end
            end
            vp = result_valid;
            tp = timeout_err;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        bit seen;

        reset     = 1'b1;
        enable    = 1'b0;
        axis_mask = 3'b111;
        tilt_in   = 3'b111;
        man_ack   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Basic round-robin 0,1,2,0 with start latency; enable drop at the end.
        tilt_in = 3'b010;
        push_meas(2'd0, 10, 32'h0000_1234, 3'b000);
        push_meas(2'd1, 10, 32'h0000_2345, 3'b000);
        push_meas(2'd2, 10, 32'h0000_3456, 3'b000);
        push_meas(2'd0, 10, 32'h0000_4567, 3'b000);
        base   = start_cnt;
        enable = 1'b1;
        n      = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (cnt_start) break;
        end
        check("start_latency", 64'(n), 64'(S + 1));
        wait_starts(base + 4, 200);
        tilt_in = 3'b111;
        enable  = 1'b0;
        wait_valid0(40);
        check("advance_tilt", 64'(cnt_tilt), 64'(1));
        @(negedge clk);
        check("drop_busy", 64'(busy), 64'(0));
        check("drop_tilt", 64'(cnt_tilt), 64'(0));

        // Sparse mask: axis 1 never selected.
        do_reset();
        axis_mask = 3'b101;
        tilt_in   = 3'b100;
        push_meas(2'd0, 10, 32'h0A0A_0001, 3'b000);
        push_meas(2'd2, 10, 32'h0A0A_0002, 3'b000);
        push_meas(2'd0, 10, 32'h0A0A_0003, 3'b000);
        push_meas(2'd2, 10, 32'h0A0A_0004, 3'b000);
        base   = start_cnt;
        enable = 1'b1;
        wait_starts(base + 4, 200);
        enable = 1'b0;
        wait_idle(60);
        check("sparse_result1", 64'(result[63:32]), 64'(0));
        check("sparse_valid1", 64'(result_valid[1]), 64'(0));

        // Timeout on axis 1, then a later good capture clears the error.
        do_reset();
        axis_mask = 3'b111;
        tilt_in   = 3'b001;
        push_meas(2'd0, 10, 32'hC000_0000, 3'b000);
        push_meas(2'd1, 10, 32'hC000_0001, 3'b000);
        push_meas(2'd2, 10, 32'hC000_0002, 3'b000);
        push_meas(2'd0, 10, 32'hC000_0003, 3'b000);
        push_meas(2'd1, 0,  32'hC000_0004, 3'b000);
        push_meas(2'd2, 10, 32'hC000_0005, 3'b000);
        push_meas(2'd0, 10, 32'hC000_0006, 3'b000);
        push_meas(2'd1, 10, 32'hC000_0007, 3'b000);
        base   = start_cnt;
        enable = 1'b1;
        wait_starts(base + 5, 300);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (timeout_err[1]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(T));
        check("timeout_seen", 64'(seen), 64'(1));
        check("timeout_err", 64'(timeout_err), 64'(3'b010));
        check("timeout_result_kept", 64'(result[63:32]), 64'(32'hC000_0001));
        wait_starts(base + 8, 300);
        enable = 1'b0;
        wait_idle(60);
        check("timeout_cleared", 64'(timeout_err), 64'(0));

        // Ack colliding with capture, then done on the final WAIT cycle.
        do_reset();
        auto_en   = 1'b0;
        axis_mask = 3'b001;
        tilt_in   = 3'b001;
        push_meas(2'd0, 10, 32'hD000_0001, 3'b001);
        push_meas(2'd0, T,  32'hD000_0002, 3'b000);
        base   = start_cnt;
        enable = 1'b1;
        wait_valid0(60);
        man_ack = 3'b001;
        @(negedge clk);
        man_ack = '0;
        check("ack_clear", 64'(result_valid[0]), 64'(0));
        wait_starts(base + 2, 100);
        enable = 1'b0;
        wait_idle(120);
        check("tie_no_timeout", 64'(timeout_err), 64'(0));
        check("tie_captured", 64'(result_valid[0]), 64'(1));
        auto_en = 1'b1;

        // Reset during WAIT aborts; a late done afterwards is ignored.
        axis_mask = 3'b111;
        tilt_in   = 3'b111;
        exp_start_q.push_back(2'd1);
        mdl_dly_q.push_back(0);
        mdl_val_q.push_back(32'hEEEE_EEEE);
        mdl_coll_q.push_back(3'b000);
        base   = start_cnt;
        enable = 1'b1;
        wait_starts(base + 1, 50);
        repeat (5) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_all_zero("midwait_reset");
        reset = 1'b0;
        @(negedge clk);
        stray_req++;
        repeat (4) @(negedge clk);
        check("late_done_result", 64'(result == '0), 64'(1));
        check("late_done_valid", 64'(result_valid), 64'(0));

        check("leftover_starts", 64'(exp_start_q.size()), 64'(0));
        check("leftover_captures", 64'(exp_cap_q.size()), 64'(0));
        check("leftover_timeouts", 64'(exp_tmo_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
